// File: rtl/systolic_input_sequencer.sv
// Front-end sequencer for an N_SIZE x N_SIZE output-stationary systolic array:
// captures A and B, feeds them diagonally skewed, then hands off to the output row counter.
module systolic_input_sequencer #(
    parameter int N_SIZE       = 5,
    parameter int DATAWIDTH    = 16,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]   matrix_a,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]   matrix_b,
    output logic [N_SIZE*DATAWIDTH-1:0]          a_left_out,
    output logic [N_SIZE*DATAWIDTH-1:0]          b_top_out,
    output logic                                 valid_in,
    output logic                                 valid_out_enable,
    output logic                                 busy,
    output logic                                 done
);

    localparam int MAT_W   = N_SIZE*N_SIZE*DATAWIDTH;
    localparam int LANE_W  = N_SIZE*DATAWIDTH;
    localparam int STEP_W  = $clog2(3*N_SIZE-1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES+1);
    localparam int CNT_W   = (STEP_W > DRAIN_W) ? STEP_W : DRAIN_W;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(3*N_SIZE-3);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES-1);
    localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(N_SIZE-1);
    localparam logic [CNT_W-1:0] N_CNT      = CNT_W'(N_SIZE);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, OUTPUT, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   step, step_nxt;
    logic [MAT_W-1:0]   a_cap, b_cap, a_cap_nxt, b_cap_nxt;
    logic [LANE_W-1:0]  a_lane_nxt, b_lane_nxt;
    logic               valid_in_nxt, valid_out_enable_nxt, busy_nxt, done_nxt;

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            step             <= '0;
            a_cap            <= '0;
            b_cap            <= '0;
            a_left_out       <= '0;
            b_top_out        <= '0;
            valid_in         <= 1'b0;
            valid_out_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nxt;
            step             <= step_nxt;
            a_cap            <= a_cap_nxt;
            b_cap            <= b_cap_nxt;
            a_left_out       <= a_lane_nxt;
            b_top_out        <= b_lane_nxt;
            valid_in         <= valid_in_nxt;
            valid_out_enable <= valid_out_enable_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        a_cap_nxt = a_cap;
        b_cap_nxt = b_cap;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FEED;
                    step_nxt  = '0;
                    a_cap_nxt = matrix_a;
                    b_cap_nxt = matrix_b;
                end
            end
            FEED: begin
                if (step == FEED_LAST) begin
                    step_nxt  = '0;
                    state_nxt = (DRAIN_CYCLES > 0) ? DRAIN : OUTPUT;
                end else begin
                    step_nxt = step + 1'b1;
                end
            end
            DRAIN: begin
                if (step == DRAIN_LAST) begin
                    step_nxt  = '0;
                    state_nxt = OUTPUT;
                end else begin
                    step_nxt = step + 1'b1;
                end
            end
            OUTPUT: begin
                if (step == OUT_LAST) begin
                    step_nxt  = '0;
                    state_nxt = DONE;
                end else begin
                    step_nxt = step + 1'b1;
                end
            end
            DONE: begin
                step_nxt  = '0;
                state_nxt = IDLE;
            end
            default: begin
                step_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Lane i carries element t-i of its row/column; the subtraction is guarded so it never wraps.
    always_comb begin
        logic [CNT_W-1:0] k;
        k                    = '0;
        a_lane_nxt           = '0;
        b_lane_nxt           = '0;
        valid_in_nxt         = (state_nxt == FEED);
        valid_out_enable_nxt = (state_nxt == OUTPUT);
        busy_nxt             = (state_nxt == FEED) || (state_nxt == DRAIN) || (state_nxt == OUTPUT);
        done_nxt             = (state_nxt == DONE);
        if (state_nxt == FEED) begin
            for (int i = 0; i < N_SIZE; i++) begin
                if (step_nxt >= CNT_W'(i)) begin
                    k = step_nxt - CNT_W'(i);
                    if (k < N_CNT) begin
                        a_lane_nxt[i*DATAWIDTH +: DATAWIDTH] =
                            a_cap_nxt[(i*N_SIZE + int'(k))*DATAWIDTH +: DATAWIDTH];
                        b_lane_nxt[i*DATAWIDTH +: DATAWIDTH] =
                            b_cap_nxt[(int'(k)*N_SIZE + i)*DATAWIDTH +: DATAWIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_input_sequencer.sv
// Self-checking bench for systolic_input_sequencer: randomized and directed runs compared
// cycle by cycle against a phase/skew model computed from the matrix contents.
module tb_systolic_input_sequencer;

    localparam int N        = 5;
    localparam int DW       = 16;
    localparam int D        = 1;
    localparam int FEED_LEN = 3*N-2;
    localparam int DONE_CYC = FEED_LEN + D + N;
    localparam int RUN_LEN  = DONE_CYC + 1;
    localparam int OW       = 2*N*DW + 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [N*N*DW-1:0]     matrix_a = '0;
    logic [N*N*DW-1:0]     matrix_b = '0;
    logic [N*DW-1:0]       a_left_out;
    logic [N*DW-1:0]       b_top_out;
    logic                  valid_in;
    logic                  valid_out_enable;
    logic                  busy;
    logic                  done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    systolic_input_sequencer #(
        .N_SIZE(N), .DATAWIDTH(DW), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .matrix_a(matrix_a),
        .matrix_b(matrix_b),
        .a_left_out(a_left_out),
        .b_top_out(b_top_out),
        .valid_in(valid_in),
        .valid_out_enable(valid_out_enable),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] observed();
        return {a_left_out, b_top_out, valid_in, valid_out_enable, busy, done};
    endfunction

    // Expected outputs cyc cycles after the start edge: feed window, drain, output, done, then idle.
    function automatic logic [OW-1:0] model(input int cyc);
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
        logic vi, voe, bs, dn;
        a = '0; b = '0; vi = 1'b0; voe = 1'b0; bs = 1'b0; dn = 1'b0;
        if (cyc < FEED_LEN) begin
            vi = 1'b1;
            bs = 1'b1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = cyc - i;
                if (k >= 0 && k < N) begin
                    a[i*DW +: DW] = ma[i][k];
                    b[i*DW +: DW] = mb[k][i];
                end
            end
        end else if (cyc < FEED_LEN + D) begin
            bs = 1'b1;
        end else if (cyc < DONE_CYC) begin
            bs  = 1'b1;
            voe = 1'b1;
        end else if (cyc == DONE_CYC) begin
            dn = 1'b1;
        end
        return {a, b, vi, voe, bs, dn};
    endfunction

    function automatic logic [N*N*DW-1:0] rand_flat();
        logic [N*N*DW-1:0] v;
        v = '0;
        for (int e = 0; e < N*N; e++) v[e*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // mode 0: A=I, B[k][j]=10k+j; mode 1: random; mode 2: all FFFF
    task automatic load_matrices(input int mode);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0: begin
                        ma[r][c] = (r == c) ? 16'd1 : 16'd0;
                        mb[r][c] = DW'(10*r + c);
                    end
                    1: begin
                        ma[r][c] = DW'($urandom);
                        mb[r][c] = DW'($urandom);
                    end
                    default: begin
                        ma[r][c] = 16'hFFFF;
                        mb[r][c] = 16'hFFFF;
                    end
                endcase
                matrix_a[(r*N + c)*DW +: DW] = ma[r][c];
                matrix_b[(r*N + c)*DW +: DW] = mb[r][c];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (observed() !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async got=%h want=0", observed());
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (observed() !== '0) begin
            failures++;
            $display("[TB] FAIL reset_idle got=%h want=0", observed());
        end
    endtask

    task automatic test_identity();
        load_matrices(0);
        begin_run();
        for (int cyc = 0; cyc <= RUN_LEN; cyc++) begin
            checks++;
            if (observed() !== model(cyc)) begin
                failures++;
                $display("[TB] FAIL identity cyc=%0d got=%h want=%h", cyc, observed(), model(cyc));
            end
            if (cyc < RUN_LEN) tick();
        end
    endtask

    task automatic test_inputs_change();
        load_matrices(1);
        begin_run();
        for (int cyc = 0; cyc <= RUN_LEN; cyc++) begin
            checks++;
            if (observed() !== model(cyc)) begin
                failures++;
                $display("[TB] FAIL inputs_change cyc=%0d got=%h want=%h", cyc, observed(), model(cyc));
            end
            matrix_a = rand_flat();
            matrix_b = rand_flat();
            start    = (cyc < RUN_LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cyc < RUN_LEN) tick();
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_matrices(1);
        start = 1'b1;
        tick();
        for (int c = 0; c < 2*(RUN_LEN+1); c++) begin
            checks++;
            if (observed() !== model(c % (RUN_LEN+1))) begin
                failures++;
                $display("[TB] FAIL back_to_back c=%0d got=%h want=%h", c, observed(), model(c % (RUN_LEN+1)));
            end
            if (c == 2*(RUN_LEN+1) - 1) start = 1'b0;
            else tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid(input int stop_cyc, input string tag);
        load_matrices(1);
        begin_run();
        for (int cyc = 0; cyc <= stop_cyc; cyc++) begin
            checks++;
            if (observed() !== model(cyc)) begin
                failures++;
                $display("[TB] FAIL %s_pre cyc=%0d got=%h want=%h", tag, cyc, observed(), model(cyc));
            end
            if (cyc < stop_cyc) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== '0) begin
            failures++;
            $display("[TB] FAIL %s_async got=%h want=0", tag, observed());
        end
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if (observed() !== '0) begin
                failures++;
                $display("[TB] FAIL %s_held got=%h want=0", tag, observed());
            end
        end
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            checks++;
            if (observed() !== '0) begin
                failures++;
                $display("[TB] FAIL %s_after got=%h want=0", tag, observed());
            end
        end
    endtask

    task automatic test_all_ones();
        load_matrices(2);
        begin_run();
        for (int cyc = 0; cyc <= RUN_LEN; cyc++) begin
            checks++;
            if (observed() !== model(cyc)) begin
                failures++;
                $display("[TB] FAIL all_ones cyc=%0d got=%h want=%h", cyc, observed(), model(cyc));
            end
            if (cyc < RUN_LEN) tick();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_inputs_change();
        test_back_to_back();
        tick();
        test_reset_mid(6, "rst_feed");
        test_reset_mid(FEED_LEN + D + 2, "rst_output");
        test_all_ones();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
